// File: rtl/sound_event_scheduler.sv
// rtl/sound_event_scheduler.sv - queued game-sound event scheduler with guard gaps
module sound_event_scheduler #(
  parameter int M        = 2,
  parameter int CLK_FREQ = 100_000_000,
  parameter int DEPTH    = 4,
  parameter int GAP      = CLK_FREQ / 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         eat_i,
  input  logic         over_i,
  input  logic         start_i,
  output logic [M-1:0] evt,
  output logic         trig,
  output logic         busy,
  output logic         drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [M-1:0]  EVT_EAT    = M'(1);
  localparam logic [M-1:0]  EVT_OVER   = M'(2);
  localparam logic [M-1:0]  EVT_START  = M'(3);
  localparam logic [31:0]   LOAD_EAT   = 32'(CLK_FREQ / 20 + GAP + 2);
  localparam logic [31:0]   LOAD_OVER  = 32'(CLK_FREQ / 2 + GAP + 2);
  localparam logic [31:0]   LOAD_START = 32'(CLK_FREQ / 10 + GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     timer_q, timer_d;
  logic [M-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [M-1:0]    evt_q, evt_d;
  logic            trig_q, trig_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic            en_q;

  logic            acc_over, acc_start, acc_eat, multi, pop, push;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [M-1:0]    mem_wdata;
  logic [M-1:0]    head;

  // Sound duration plus guard gap plus the two IDLE/ISSUE overhead cycles.
  function automatic logic [31:0] load_for(input logic [M-1:0] code);
    case (code)
      EVT_OVER:  load_for = LOAD_OVER;
      EVT_START: load_for = LOAD_START;
      default:   load_for = LOAD_EAT;
    endcase
  endfunction

  assign head = mem_q[rd_ptr_q];
  assign pop  = (state_q == S_ISSUE);

  // Input arbitration (OVER > START > EAT) and queue bookkeeping; OVER flushes to {OVER}.
  always_comb begin
    acc_over  = en_q && over_i;
    acc_start = en_q && start_i && !over_i;
    acc_eat   = en_q && eat_i && !over_i && !start_i;
    multi     = en_q && ((eat_i && over_i) || (eat_i && start_i) || (over_i && start_i));
    push      = (acc_eat || acc_start) && ((count_q < DEPTH_C) || pop);
    drop_d    = multi || ((acc_eat || acc_start) && !push);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = acc_start ? EVT_START : EVT_EAT;
    if (acc_over) begin
      mem_we    = 1'b1;
      mem_waddr = '0;
      mem_wdata = EVT_OVER;
      wr_ptr_d  = AW'(1);
      rd_ptr_d  = '0;
      count_d   = (AW + 1)'(1);
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW + 1)'(1);
      end
    end
  end

  // Issue FSM: IDLE waits for a queued code, ISSUE strobes it, WAIT runs out the timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    trig_d  = 1'b0;
    evt_d   = evt_q;
    busy_d  = (count_q != '0) || (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        trig_d  = 1'b1;
        evt_d   = head;
        timer_d = load_for(head);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q <= 32'd1) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Control and output registers; en_q masks inputs on the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      evt_q    <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      evt_q    <= evt_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      en_q     <= 1'b1;
    end
  end

  assign evt  = evt_q;
  assign trig = trig_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// tb/tb_sound_event_scheduler.sv - vector table plus multi-cycle sequences for sound_event_scheduler
module tb_sound_event_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eat_i = 1'b0;
  logic       over_i = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] evt;
  logic       trig, busy, drop;

  sound_event_scheduler #(
    .M(2), .CLK_FREQ(1000), .DEPTH(4), .GAP(10)
  ) dut (
    .clk(clk), .rst(rst), .eat_i(eat_i), .over_i(over_i), .start_i(start_i),
    .evt(evt), .trig(trig), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   trig_cyc[$];
  int   trig_evt[$];
  int   drop_n = 0;
  int   b2b_n = 0;
  logic trig_prev = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every trig (edge index, code), drop pulse and back-to-back trig.
  always @(negedge clk) begin
    if (trig) begin
      trig_cyc.push_back(cyc);
      trig_evt.push_back(int'(evt));
      if (trig_prev) b2b_n = b2b_n + 1;
    end
    if (drop) drop_n = drop_n + 1;
    trig_prev = trig;
  end

  typedef struct {
    logic       rst, eat, over, start;
    logic [1:0] evt;
    logic       trig, busy, drop;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic e, input logic o, input logic s, output int e0);
    eat_i = e; over_i = o; start_i = s;
    @(posedge clk);
    #1;
    e0 = cyc;
    eat_i = 1'b0; over_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int max, output int at);
    at = -1;
    for (int k = 0; k < max; k++) begin
      if (!busy) begin
        at = cyc;
        break;
      end
      tick(1);
    end
    if (at < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, max);
    end
  endtask

  function automatic int tc(input int i);
    return (i < trig_cyc.size()) ? trig_cyc[i] : -1000000;
  endfunction

  function automatic int te(input int i);
    return (i < trig_evt.size()) ? trig_evt[i] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, at, b, d, nz;

    //          rst eat ovr sta  evt  trg bsy drp
    tbl[0]  = '{1, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 2'd0, 0, 0, 0};  // pulse on release edge ignored
    tbl[2]  = '{0, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 2'd0, 0, 0, 0};  // E0
    tbl[4]  = '{0, 0, 0, 0, 2'd0, 0, 1, 0};  // E1
    tbl[5]  = '{0, 0, 0, 0, 2'd1, 1, 1, 0};  // E2: issue EAT
    tbl[6]  = '{0, 0, 0, 0, 2'd1, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 2'd0, 0, 0, 0};  // abort mid-WAIT
    tbl[8]  = '{0, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 2'd0, 0, 0, 1};  // EAT+OVER collide
    tbl[10] = '{0, 0, 0, 0, 2'd0, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 2'd2, 1, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 2'd2, 0, 1, 0};
    tbl[13] = '{1, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 1, 2'd0, 0, 0, 1};  // START+EAT collide
    tbl[16] = '{0, 0, 0, 0, 2'd0, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 2'd3, 1, 1, 0};

    #1;
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; eat_i = tbl[i].eat; over_i = tbl[i].over; start_i = tbl[i].start;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {evt,trig,busy,drop}", i),
          int'({evt, trig, busy, drop}),
          int'({tbl[i].evt, tbl[i].trig, tbl[i].busy, tbl[i].drop}));
    end
    eat_i = 1'b0; over_i = 1'b0; start_i = 1'b0;

    // Single EAT: latency 2 edges, busy falls 63 cycles after trig.
    do_reset();
    b = trig_cyc.size();
    pulse(1, 0, 0, e0);
    tick(3);
    wait_idle(200, at);
    chk("eat trig count", trig_cyc.size() - b, 1);
    chk("eat latency", tc(b) - e0, 2);
    chk("eat code", te(b), 1);
    chk("eat busy fall", at - tc(b), 63);

    // START then EAT five cycles later: 114 cycle spacing.
    do_reset();
    b = trig_cyc.size();
    pulse(0, 0, 1, e0);
    tick(4);
    pulse(1, 0, 0, e1);
    tick(3);
    wait_idle(400, at);
    chk("start/eat trig count", trig_cyc.size() - b, 2);
    chk("start code", te(b), 3);
    chk("start latency", tc(b) - e0, 2);
    chk("eat after start code", te(b + 1), 1);
    chk("start spacing", tc(b + 1) - tc(b), 114);

    // Six EATs while playing: four queued, two dropped.
    do_reset();
    b = trig_cyc.size();
    d = drop_n;
    pulse(1, 0, 0, e0);
    tick(3);
    for (int k = 0; k < 6; k++) begin
      pulse(1, 0, 0, e1);
      tick(1);
    end
    wait_idle(600, at);
    chk("overflow trig count", trig_cyc.size() - b, 5);
    chk("overflow drops", drop_n - d, 2);
    for (int k = 0; k < 5; k++) chk($sformatf("overflow code%0d", k), te(b + k), 1);
    for (int k = 0; k < 4; k++) chk($sformatf("overflow spacing%0d", k), tc(b + k + 1) - tc(b + k), 64);

    // Queue {EAT,START,EAT} then OVER: only OVER follows, no drops.
    do_reset();
    b = trig_cyc.size();
    d = drop_n;
    pulse(1, 0, 0, e0);
    tick(3);
    pulse(1, 0, 0, e1); tick(1);
    pulse(0, 0, 1, e1); tick(1);
    pulse(1, 0, 0, e1); tick(1);
    pulse(0, 1, 0, e1);
    tick(3);
    wait_idle(1000, at);
    tick(20);
    chk("flush trig count", trig_cyc.size() - b, 2);
    chk("flush code", te(b + 1), 2);
    chk("flush spacing", tc(b + 1) - tc(b), 64);
    chk("flush drops", drop_n - d, 0);

    // Reset 20 cycles into WAIT with two queued entries.
    do_reset();
    pulse(1, 0, 0, e0);
    tick(2);
    pulse(1, 0, 0, e1); tick(1);
    pulse(1, 0, 0, e1);
    while (cyc < e0 + 22) tick(1);
    rst = 1'b1;
    #1;
    chk("async reset outputs", int'({evt, trig, busy, drop}), 0);
    tick(2);
    rst = 1'b0;
    b = trig_cyc.size();
    d = drop_n;
    nz = 0;
    for (int k = 0; k < 700; k++) begin
      tick(1);
      if ({evt, trig, busy, drop} != 5'd0) nz++;
    end
    chk("post-reset active cycles", nz, 0);
    chk("post-reset trigs", trig_cyc.size() - b, 0);
    chk("post-reset drops", drop_n - d, 0);

    chk("back-to-back trigs", b2b_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
